muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multi-cycle multiply/divide execute unit with a start/done handshake.
//  Successor to the single-mode multiplier: generalised to WIDTH bits and five modes
//  (MUL, SMULH, UMULH, SDIV, UDIV), with flush abort and divide-by-zero early-out.
//  Sits in execute; decode raises start and stalls the PC until done.
// PARAMETERS
//  WIDTH  64  operand/result width in bits; any value >= 4
// PORTS
//  clk           in   1      clock; all state on rising edge
//  rst           in   1      asynchronous, active-high reset
//  start         in   1      launch op; sampled only when busy=0
//  op            in   3      operation code, `MD_* constants
//  a             in   WIDTH  operand A (multiplicand / dividend)
//  b             in   WIDTH  operand B (multiplier / divisor)
//  flush         in   1      abort in-flight op, no done
//  busy          out  1      op in flight (RUN or FIX)
//  done          out  1      one-cycle pulse; result valid
//  result        out  WIDTH  registered result; held until next completion
//  div_by_zero   out  1      valid with done; 1 if SDIV/UDIV with b==0
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, result=0, div_by_zero=0; counter and operand regs 0.
//  States: IDLE, RUN, FIX, DONE. busy=1 in RUN and FIX only; done=1 in DONE only.
//  IDLE/DONE + start: latch op, |a|, |b| and sign flags; cycle counter=0; next state RUN.
//   - start in DONE is accepted (back-to-back); otherwise DONE -> IDLE.
//  Early-outs from IDLE/DONE + start, straight to DONE, result updated at that edge:
//   - SDIV/UDIV with b==0 -> result=0, div_by_zero=1.
//   - op outside the 5 codes -> result=0, div_by_zero=0.
//  RUN: one radix-2 step per cycle, exactly WIDTH cycles, then FIX.
//   - mult: shift-add over 2*WIDTH accumulator on magnitudes.
//   - div: restoring shift-subtract; quotient built MSB-first.
//  FIX (1 cycle): sign correction, select, register result; then DONE.
//   - MUL: low WIDTH of product (sign-insensitive; operands treated unsigned).
//   - SMULH: high WIDTH of 2*WIDTH signed product (negate full 2W product if signs differ).
//   - UMULH: high WIDTH of unsigned product.
//   - SDIV: quotient truncated toward zero; negate if signs differ; MIN/-1 -> MIN (wrap).
//   - UDIV: unsigned quotient. Remainder not exported.
//  Latency: start high in cycle 0 -> RUN cycles 1..WIDTH, FIX cycle WIDTH+1,
//   done=1 in cycle WIDTH+2. Early-out: done=1 in cycle 1.
//  start while busy=1: ignored, no effect on in-flight op.
//  flush: highest priority after rst; in any state next state IDLE, done suppressed,
//   result and div_by_zero unchanged; flush with start in same cycle -> start dropped.
//  div_by_zero cleared on every accepted start; value meaningful only with done.
//  rst mid-op: immediate return to reset values, no done.
//  Operands a/b/op need only be valid in the start cycle.
// STRUCTURE
//  constants.vh: `MD_MUL=3'd0, `MD_SMULH=3'd1, `MD_UMULH=3'd2, `MD_SDIV=3'd3,
//   `MD_UDIV=3'd4; state encodings `MD_ST_IDLE/RUN/FIX/DONE.
//  Sub-module muldiv_core: combinational single-step datapath
//   (acc, operand, mode) -> next acc; FSM, counter ($clog2(WIDTH)+1 bits)
//   and sign logic stay in muldiv_unit.
// TESTING (WIDTH=8 unless noted; cycle 0 = start cycle)
//  MUL a=13 b=11 -> busy cycles 1..9, done cycle 10, result=0x8F, div_by_zero=0.
//  SMULH a=0xFD(-3) b=5 -> 0xFF; UMULH a=0xFF b=0xFF -> 0xFE; MUL 0xFF*0xFF -> 0x01.
//  SDIV 0xF9(-7)/2 -> 0xFD; UDIV 200/7 -> 28; SDIV 0x80/0xFF -> 0x80.
//  UDIV 5/0 -> done cycle 1, result=0, div_by_zero=1; next MUL 2*3 -> 6, flag 0.
//  MUL start, second start cycle 3 ignored; flush cycle 4 -> busy=0 cycle 5, no done;
//   rst cycle 6 of a new op -> all outputs 0.
//  WIDTH=64: UMULH 2^63 * 4 -> 2; start in DONE cycle -> second done WIDTH+2 later.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, state encoding and small decode helpers
// for the iterative multiply/divide execute unit.
package muldiv_unit_pkg;

    localparam logic [2:0] MD_MUL   = 3'd0;
    localparam logic [2:0] MD_SMULH = 3'd1;
    localparam logic [2:0] MD_UMULH = 3'd2;
    localparam logic [2:0] MD_SDIV  = 3'd3;
    localparam logic [2:0] MD_UDIV  = 3'd4;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_RUN  = 2'd1,
        MD_ST_FIX  = 2'd2,
        MD_ST_DONE = 2'd3
    } md_state_e;

    function automatic logic md_op_valid(input logic [2:0] op);
        return op <= MD_UDIV;
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_SDIV) || (op == MD_UDIV);
    endfunction

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_SMULH) || (op == MD_SDIV);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// One radix-2 step: shift-add multiply or restoring divide
// over a 2*WIDTH accumulator.
module muldiv_core #(
    parameter int WIDTH = 64
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               div,
    output logic [2*WIDTH-1:0] acc_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;

    // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
              + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        if (div) begin
            if (trial[WIDTH])
                acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
            else
                acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: start/done handshake, flush abort,
// divide-by-zero and illegal-op early-out.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               dbz_q, dbz_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .acc     (acc_q),
        .opnd    (opnd_q),
        .div     (md_is_div(op_q)),
        .acc_nxt (acc_step)
    );

    always_comb begin
        a_neg  = md_is_signed(op) & a[WIDTH-1];
        b_neg  = md_is_signed(op) & b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        prod_s = neg_q ? -acc_q : acc_q;
        quot_s = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            MD_ST_IDLE, MD_ST_DONE: begin
                state_d = MD_ST_IDLE;
                if (start) begin
                    op_d   = op;
                    neg_d  = a_neg ^ b_neg;
                    cnt_d  = '0;
                    dbz_d  = 1'b0;
                    acc_d  = {{WIDTH{1'b0}}, md_is_div(op) ? a_mag : b_mag};
                    opnd_d = md_is_div(op) ? b_mag : a_mag;
                    if (!md_op_valid(op)) begin
                        res_d   = '0;
                        state_d = MD_ST_DONE;
                    end else if (md_is_div(op) && (b == '0)) begin
                        res_d   = '0;
                        dbz_d   = 1'b1;
                        state_d = MD_ST_DONE;
                    end else begin
                        state_d = MD_ST_RUN;
                    end
                end
            end
            MD_ST_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST)
                    state_d = MD_ST_FIX;
            end
            MD_ST_FIX: begin
                state_d = MD_ST_DONE;
                case (op_q)
                    MD_MUL:   res_d = acc_q[WIDTH-1:0];
                    MD_SMULH: res_d = prod_s[2*WIDTH-1:WIDTH];
                    MD_UMULH: res_d = acc_q[2*WIDTH-1:WIDTH];
                    MD_SDIV:  res_d = quot_s;
                    default:  res_d = acc_q[WIDTH-1:0];
                endcase
            end
            default: state_d = MD_ST_IDLE;
        endcase

        // abort wins over everything, including a same-cycle start
        if (flush) begin
            state_d = MD_ST_IDLE;
            res_d   = res_q;
            dbz_d   = dbz_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == MD_ST_RUN) || (state_q == MD_ST_FIX);
    assign done        = (state_q == MD_ST_DONE);
    assign result      = res_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at WIDTH=8 and WIDTH=64: vector table,
// done-time scoreboard, flush/reset/back-to-back sequences.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start8, flush8, busy8, done8, dbz8;
    logic [2:0] op8;
    logic [7:0] a8, b8, res8;

    logic        start64, flush64, busy64, done64, dbz64;
    logic [2:0]  op64;
    logic [63:0] a64, b64, res64;

    muldiv_unit #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .flush(flush8), .busy(busy8), .done(done8), .result(res8),
        .div_by_zero(dbz8)
    );

    muldiv_unit #(.WIDTH(64)) u64 (
        .clk(clk), .rst(rst), .start(start64), .op(op64), .a(a64), .b(b64),
        .flush(flush64), .busy(busy64), .done(done64), .result(res64),
        .div_by_zero(dbz64)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       dbz;
        int         lat;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t q8[$];
    exp_t q64[$];
    int   nchk = 0;
    int   nerr = 0;
    int   cyc  = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && done8 === 1'b1) begin
            if (q8.size() == 0) begin
                chk("unexpected_done8", 64'd1, 64'd0);
            end else begin
                e = q8.pop_front();
                chk("res8", {56'd0, res8}, e.res);
                chk("dbz8", {63'd0, dbz8}, {63'd0, e.dbz});
                chk("done_cycle8", 64'(cyc), 64'(e.due));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && done64 === 1'b1) begin
            if (q64.size() == 0) begin
                chk("unexpected_done64", 64'd1, 64'd0);
            end else begin
                e = q64.pop_front();
                chk("res64", res64, e.res);
                chk("dbz64", {63'd0, dbz64}, {63'd0, e.dbz});
                chk("done_cycle64", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue8(input vec_t v);
        tick();
        start8 = 1'b1;
        op8 = v.op;
        a8 = v.a;
        b8 = v.b;
        q8.push_back('{res: {56'd0, v.res}, dbz: v.dbz, due: cyc + v.lat});
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        op8 = 3'($urandom);
    endtask

    task automatic wait8();
        for (int i = 0; i < 100 && q8.size() != 0; i++) @(posedge clk);
        if (q8.size() != 0) begin
            chk("timeout8", 64'd1, 64'd0);
            q8.delete();
        end
    endtask

    task automatic issue64(input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] res);
        tick();
        start64 = 1'b1;
        op64 = op;
        a64 = a;
        b64 = b;
        q64.push_back('{res: res, dbz: 1'b0, due: cyc + 66});
        tick();
        start64 = 1'b0;
        a64 = {$urandom, $urandom};
        b64 = {$urandom, $urandom};
    endtask

    task automatic wait64();
        for (int i = 0; i < 300 && q64.size() != 0; i++) @(posedge clk);
        if (q64.size() != 0) begin
            chk("timeout64", 64'd1, 64'd0);
            q64.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[$];
        logic [7:0] prev_res;
        logic       prev_dbz;
        int         found;

        rst = 1'b1;
        start8 = 0; flush8 = 0; op8 = 0; a8 = 0; b8 = 0;
        start64 = 0; flush64 = 0; op64 = 0; a64 = 0; b64 = 0;

        vt.push_back('{MD_MUL,   8'd13,  8'd11,  8'h8F, 1'b0, 10});
        vt.push_back('{MD_SMULH, 8'hFD,  8'd5,   8'hFF, 1'b0, 10});
        vt.push_back('{MD_UMULH, 8'hFF,  8'hFF,  8'hFE, 1'b0, 10});
        vt.push_back('{MD_MUL,   8'hFF,  8'hFF,  8'h01, 1'b0, 10});
        vt.push_back('{MD_SDIV,  8'hF9,  8'd2,   8'hFD, 1'b0, 10});
        vt.push_back('{MD_UDIV,  8'd200, 8'd7,   8'd28, 1'b0, 10});
        vt.push_back('{MD_SDIV,  8'h80,  8'hFF,  8'h80, 1'b0, 10});
        vt.push_back('{MD_UDIV,  8'd5,   8'd0,   8'h00, 1'b1, 1});
        vt.push_back('{MD_MUL,   8'd2,   8'd3,   8'd6,  1'b0, 10});
        vt.push_back('{MD_SMULH, 8'h80,  8'h80,  8'h40, 1'b0, 10});
        vt.push_back('{MD_SMULH, 8'h7F,  8'h81,  8'hC0, 1'b0, 10});
        vt.push_back('{MD_SDIV,  8'd9,   8'hFD,  8'hFD, 1'b0, 10});
        vt.push_back('{MD_SDIV,  8'd7,   8'd0,   8'h00, 1'b1, 1});
        vt.push_back('{3'd7,     8'd5,   8'd5,   8'h00, 1'b0, 1});
        vt.push_back('{MD_UDIV,  8'hFF,  8'd1,   8'hFF, 1'b0, 10});
        vt.push_back('{MD_MUL,   8'd21,  8'd12,  8'hFC, 1'b0, 10});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy8",  {63'd0, busy8}, 64'd0);
        chk("rst_done8",  {63'd0, done8}, 64'd0);
        chk("rst_res8",   {56'd0, res8},  64'd0);
        chk("rst_dbz8",   {63'd0, dbz8},  64'd0);
        chk("rst_res64",  res64,          64'd0);
        tick();
        rst = 1'b0;

        foreach (vt[i]) begin
            issue8(vt[i]);
            wait8();
        end
        prev_res = vt[vt.size()-1].res;
        prev_dbz = vt[vt.size()-1].dbz;

        // busy window of a single MUL
        tick();
        start8 = 1'b1; op8 = MD_MUL; a8 = 8'd13; b8 = 8'd11;
        q8.push_back('{res: 64'h8F, dbz: 1'b0, due: cyc + 10});
        @(negedge clk);
        chk("busy_c0", {63'd0, busy8}, 64'd0);
        tick();
        start8 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("busy_c%0d", k), {63'd0, busy8},
                {63'd0, (k <= 9) ? 1'b1 : 1'b0});
        end
        wait8();
        prev_res = 8'h8F;
        prev_dbz = 1'b0;

        // start while busy is ignored; flush aborts without done
        tick();
        start8 = 1'b1; op8 = MD_MUL; a8 = 8'd3; b8 = 8'd5;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        start8 = 1'b1; op8 = MD_UDIV; a8 = 8'd5; b8 = 8'd0;
        tick();
        start8 = 1'b0; flush8 = 1'b1;
        @(negedge clk);
        chk("busy_ignored_start", {63'd0, busy8}, 64'd1);
        chk("done_ignored_start", {63'd0, done8}, 64'd0);
        tick();
        flush8 = 1'b0;
        @(negedge clk);
        chk("flush_busy", {63'd0, busy8}, 64'd0);
        chk("flush_done", {63'd0, done8}, 64'd0);
        chk("flush_res",  {56'd0, res8},  {56'd0, prev_res});
        chk("flush_dbz",  {63'd0, dbz8},  {63'd0, prev_dbz});
        repeat (15) tick();

        // flush with start in the same cycle drops the start
        start8 = 1'b1; flush8 = 1'b1; op8 = MD_UDIV; a8 = 8'd1; b8 = 8'd0;
        tick();
        start8 = 1'b0; flush8 = 1'b0;
        @(negedge clk);
        chk("flush_start_busy", {63'd0, busy8}, 64'd0);
        chk("flush_start_done", {63'd0, done8}, 64'd0);
        chk("flush_start_dbz",  {63'd0, dbz8},  {63'd0, prev_dbz});
        repeat (3) tick();

        // reset in cycle 6 of an op
        start8 = 1'b1; op8 = MD_UDIV; a8 = 8'd100; b8 = 8'd3;
        tick();
        start8 = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {63'd0, busy8}, 64'd0);
        chk("midrst_done", {63'd0, done8}, 64'd0);
        chk("midrst_res",  {56'd0, res8},  64'd0);
        chk("midrst_dbz",  {63'd0, dbz8},  64'd0);
        tick();
        rst = 1'b0;
        issue8('{MD_UDIV, 8'd100, 8'd3, 8'd33, 1'b0, 10});
        wait8();

        // WIDTH=64: UMULH then a start accepted in the DONE cycle
        issue64(MD_UMULH, 64'h8000_0000_0000_0000, 64'd4, 64'd2);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            if (done64 === 1'b1) found = 1;
        end
        if (found == 0) begin
            chk("done64_seen", 64'd0, 64'd1);
        end else begin
            start64 = 1'b1; op64 = MD_MUL;
            a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'd3;
            q64.push_back('{res: 64'hFFFF_FFFF_FFFF_FFFD, dbz: 1'b0,
                            due: cyc + 66});
            tick();
            start64 = 1'b0;
        end
        wait64();
        issue64(MD_SDIV, -64'sd100, 64'd7, -64'sd14);
        wait64();

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
